// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_if
// Description : Request/response bundle between the EX stage (master) and the
//               multi-cycle multiply/divide unit (slave).
//               master drives : start, funct, operand_1, operand_2, flush,
//                               stall_in
//               slave drives  : done, busy, result ({HI, LO})
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_if;
  localparam int DATA_BUS     = 32;
  localparam int MULT_DIV_BUS = 64;

  logic                    start;
  logic [5:0]              funct;
  logic [DATA_BUS-1:0]     operand_1;
  logic [DATA_BUS-1:0]     operand_2;
  logic                    flush;
  logic                    stall_in;
  logic                    done;
  logic                    busy;
  logic [MULT_DIV_BUS-1:0] result;

  modport master (
    output start, funct, operand_1, operand_2, flush, stall_in,
    input  done, busy, result
  );

  modport slave (
    input  start, funct, operand_1, operand_2, flush, stall_in,
    output done, busy, result
  );
endinterface
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
// Module      : mult_div
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit sitting beside EX.
//               Radix-2 shift-add multiply and restoring radix-2 divide, each
//               32 iterations; result is {HI, LO}.
//               Optional build macro MULT_DIV_FAST_MULT_EN: multiplies are
//               done by one combinational 32x32 product (done in cycle 1).
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - mult_div_if.slave (start/funct/operands/flush/
//                      stall_in in; done/busy/result out)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div (
  input  wire logic   clk,
  input  wire logic   rst,
  mult_div_if.slave   bus
);

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] LAST_ITER   = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: acc = partial product. Divide: acc = {remainder, quotient}.
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;     // multiplicand, shifted left each step
  logic [31:0] opb_q, opb_d;         // multiplier (shifted right) or divisor
  logic        neg_q, neg_d;         // negate product / quotient
  logic        rem_neg_q, rem_neg_d; // negate remainder (dividend sign)
  logic [63:0] result_q, result_d;

  // ---------------- operand conditioning in IDLE ----------------
  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;

  assign is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
  assign a_neg     = is_signed & bus.operand_1[31];
  assign b_neg     = is_signed & bus.operand_2[31];
  assign a_abs     = a_neg ? (~bus.operand_1 + 32'd1) : bus.operand_1;
  assign b_abs     = b_neg ? (~bus.operand_2 + 32'd1) : bus.operand_2;

  // ---------------- iteration datapath ----------------
  logic [63:0] mul_sum, mul_fix;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff, quo_fix, rem_fix;
  logic [63:0] div_next;

  assign mul_sum = opb_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_fix = neg_q ? (~mul_sum + 64'd1) : mul_sum;

  // Shift the pair left by one; the bit leaving the quotient enters the
  // remainder. The trial difference fits in 32 bits whenever it is kept.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[31:0] - opb_q;
  assign div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                            : {div_shift[31:0], acc_q[30:0], 1'b0};
  // Quotient negation wraps in 32 bits, so 0x8000_0000 / -1 stays 0x8000_0000.
  assign quo_fix   = neg_q     ? (~div_next[31:0]  + 32'd1) : div_next[31:0];
  assign rem_fix   = rem_neg_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];

`ifdef MULT_DIV_FAST_MULT_EN
  logic [63:0] fast_uprod, fast_sprod;
  assign fast_uprod = {32'd0, bus.operand_1} * {32'd0, bus.operand_2};
  // Sign-extended operands; the low 64 bits equal the signed product.
  assign fast_sprod = {{32{bus.operand_1[31]}}, bus.operand_1} *
                      {{32{bus.operand_2[31]}}, bus.operand_2};
`endif

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.funct)
            FUNCT_MULT, FUNCT_MULTU: begin
`ifdef MULT_DIV_FAST_MULT_EN
              result_d = (bus.funct == FUNCT_MULT) ? fast_sprod : fast_uprod;
              state_d  = S_DONE;
`else
              acc_d   = 64'd0;
              mcand_d = {32'd0, a_abs};
              opb_d   = b_abs;
              neg_d   = a_neg ^ b_neg;
              cnt_d   = 6'd0;
              state_d = S_MUL;
`endif
            end
            FUNCT_DIV, FUNCT_DIVU: begin
              if (bus.operand_2 == 32'd0) begin
                // Divide by zero: raw dividend in HI, all ones in LO.
                result_d = {bus.operand_1, 32'hFFFF_FFFF};
                state_d  = S_DONE;
              end else begin
                acc_d     = {32'd0, a_abs};
                opb_d     = b_abs;
                neg_d     = a_neg ^ b_neg;
                rem_neg_d = a_neg;
                cnt_d     = 6'd0;
                state_d   = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (!bus.start) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = mul_sum;
          mcand_d = {mcand_q[62:0], 1'b0};
          opb_d   = {1'b0, opb_q[31:1]};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            result_d = mul_fix;
            state_d  = S_DONE;
          end
        end
      end

      S_DIV: begin
        if (!bus.start) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            result_d = {rem_fix, quo_fix};
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!bus.stall_in) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except reset and never touches result.
    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      opb_q     <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.result = result_q;

endmodule
`default_nettype wire
